// File: rtl/risc231_io_pkg.sv
// rtl/risc231_io_pkg.sv - shared constants and types for RISC231 memory-mapped I/O
// Purpose: UART TX register offsets, STATUS bit positions and transmitter state enum.
// Ports: none (package).
package risc231_io_pkg;

    // Word offsets within the UART TX window (mem_addr[3:2])
    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

    // STATUS register bit positions
    localparam int UART_STAT_BUSY    = 0;
    localparam int UART_STAT_FULL    = 1;
    localparam int UART_STAT_EMPTY   = 2;
    localparam int UART_STAT_OVERRUN = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue feeding the UART transmitter
// Purpose: circular queue of DEPTH entries, or a single holding register when DEPTH == 1.
//          A push while full is accepted only if a pop frees a slot in the same cycle.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (empties the queue)
//   push, din    - enqueue request and byte
//   pop, dout    - dequeue request and head byte (combinational)
//   full, empty  - occupancy flags
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic do_pop;
    logic do_push;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    generate
        if (DEPTH == 1) begin : g_hold
            logic [WIDTH-1:0] hold;
            logic             valid;

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid <= 1'b0;
                    hold  <= '0;
                end else if (do_push) begin
                    // Covers push+pop on a full register: the new byte replaces the popped one
                    hold  <= din;
                    valid <= 1'b1;
                end else if (do_pop) begin
                    valid <= 1'b0;
                end
            end

            assign dout  = hold;
            assign full  = valid;
            assign empty = !valid;
        end else begin : g_ring
            localparam int AW = $clog2(DEPTH);

            logic [WIDTH-1:0] mem [DEPTH];
            logic [AW:0]      wr_ptr;
            logic [AW:0]      rd_ptr;

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
                    if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
                end
            end

            // When full, the write slot equals the read slot; the head is read
            // combinationally before the edge, so push+pop on full is safe.
            always_ff @(posedge clk) begin
                if (do_push) mem[wr_ptr[AW-1:0]] <= din;
            end

            assign dout  = mem[rd_ptr[AW-1:0]];
            assign empty = (wr_ptr == rd_ptr);
            assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        end
    endgenerate

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter for the RISC231-M1 data bus
// Purpose: register decode (TXDATA/STATUS/BAUDDIV), baud counter and transmit FSM.
// Configuration: define UART_TX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a
//                single holding register is used.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   sel, wr    - peripheral select and store strobe
//   addr       - word offset within the window
//   din, dout  - store data, combinational read data (0 when not selected)
//   txd        - serial output, idles high
module uart_tx_mmio #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        wr,
    input  logic [1:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        txd
);
    import risc231_io_pkg::*;

`ifdef UART_TX_FIFO_EN
    localparam int QDEPTH = FIFO_DEPTH;
`else
    localparam int QDEPTH = 1;
`endif

    localparam int unused_fifo_depth = FIFO_DEPTH;

    uart_tx_state_t state;
    logic [15:0]    bauddiv;
    logic [15:0]    frame_div;   // BAUDDIV latched at frame start
    logic [15:0]    baud_cnt;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic           overrun;

    logic           push;
    logic           pop;
    logic           q_full;
    logic           q_empty;
    logic [7:0]     q_dout;
    logic           bit_end;
    logic           unused_din;

    assign unused_din = ^din[31:16];

    assign push    = sel && wr && (addr == UART_TXDATA);
    assign bit_end = (baud_cnt == 16'd0);
    // The transmitter takes a byte when idle, or at the end of a stop bit for
    // gapless back-to-back frames.
    assign pop     = !q_empty && ((state == UART_IDLE) || (state == UART_STOP && bit_end));

    uart_tx_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din[7:0]),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            bauddiv <= 16'(CLKS_PER_BIT);
        end else if (sel && wr && addr == UART_BAUDDIV) begin
            bauddiv <= (din[15:0] == 16'd0) ? 16'd1 : din[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (sel && wr && addr == UART_STATUS) begin
            overrun <= 1'b0;
        end else if (push && q_full && !pop) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= UART_IDLE;
            txd       <= 1'b1;
            shreg     <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            frame_div <= 16'(CLKS_PER_BIT);
        end else begin
            case (state)
                UART_IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg     <= q_dout;
                        frame_div <= bauddiv;
                        baud_cnt  <= bauddiv - 16'd1;
                        txd       <= 1'b0;
                        state     <= UART_START;
                    end
                end
                UART_START: begin
                    if (bit_end) begin
                        bit_idx  <= 3'd0;
                        baud_cnt <= frame_div - 16'd1;
                        txd      <= shreg[0];
                        state    <= UART_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                UART_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= frame_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= UART_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                UART_STOP: begin
                    if (bit_end) begin
                        if (pop) begin
                            shreg     <= q_dout;
                            frame_div <= bauddiv;
                            baud_cnt  <= bauddiv - 16'd1;
                            txd       <= 1'b0;
                            state     <= UART_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= UART_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= UART_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dout = 32'd0;
        if (sel) begin
            case (addr)
                UART_STATUS: begin
                    dout[UART_STAT_BUSY]    = (state != UART_IDLE);
                    dout[UART_STAT_FULL]    = q_full;
                    dout[UART_STAT_EMPTY]   = q_empty;
                    dout[UART_STAT_OVERRUN] = overrun;
                end
                UART_BAUDDIV: dout = {16'd0, bauddiv};
                default:      dout = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
    import risc231_io_pkg::*;

`ifdef UART_TX_FIFO_EN
    localparam int QD = 4;
`else
    localparam int QD = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        txd;

    int checks = 0;
    int errors = 0;

    bit tx_log[$];
    int log_base;
    bit exp_q[$];

    uart_tx_mmio dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .wr    (wr),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    // txd only changes on rising edges, so the falling edge gives one clean sample per cycle
    always @(negedge clk) tx_log.push_back(txd);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; din = d;
        tick();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        sel = 1'b1; wr = 1'b0; addr = a;
        #1;
        d = dout;
        sel = 1'b0;
    endtask

    task automatic start_log();
        log_base = tx_log.size();
        exp_q.delete();
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    // Reference 8N1 frame: start 0, eight data bits LSB first, stop 1, each d cycles wide
    task automatic add_frame(input logic [7:0] b, input int d);
        for (int r = 0; r < d; r++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            for (int r = 0; r < d; r++) exp_q.push_back(b[i]);
        for (int r = 0; r < d; r++) exp_q.push_back(1'b1);
    endtask

    task automatic wait_log();
        for (int t = 0; t < exp_q.size() + 50 && tx_log.size() < log_base + exp_q.size(); t++)
            tick();
    endtask

    // -1 when the logged waveform matches, -2 when too few samples, else first bad index
    function automatic int first_mismatch();
        if (tx_log.size() < log_base + exp_q.size()) return -2;
        for (int i = 0; i < exp_q.size(); i++)
            if (tx_log[log_base + i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b1; sel = 1'b0; wr = 1'b0; addr = 2'd0; din = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b expected 1", txd); end
        read_reg(UART_STATUS, r);
        checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL reset_status: got %h expected 4", r); end
        read_reg(UART_BAUDDIV, r);
        checks++;
        if (r !== 32'd16) begin errors++; $display("FAIL reset_bauddiv: got %0d expected 16", r); end
        read_reg(UART_TXDATA, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_txdata_read: got %h expected 0", r); end
        read_reg(2'd3, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reset_reserved_read: got %h expected 0", r); end
    endtask

    task automatic test_single_byte();
        logic [31:0] s;
        int busy_cnt;
        int m;
        write_reg(UART_BAUDDIV, 32'd4);
        write_reg(UART_TXDATA, 32'h0000_00A5);
        start_log();
        add_idle(1);
        add_frame(8'hA5, 4);
        busy_cnt = 0;
        s = '0;
        for (int t = 0; t < 60; t++) begin
            tick();
            read_reg(UART_STATUS, s);
            if (s[0]) busy_cnt++;
            else break;
        end
        checks++;
        if (busy_cnt !== 40) begin errors++; $display("FAIL single_busy_len: got %0d expected 40", busy_cnt); end
        checks++;
        if (s !== 32'h4) begin errors++; $display("FAIL single_status_after: got %h expected 4", s); end
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL single_wave: first bad sample %0d expected -1", m); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        int m;
        write_reg(UART_BAUDDIV, 32'd2);
        write_reg(UART_TXDATA, 32'h55);
        start_log();
        write_reg(UART_TXDATA, 32'h0F);
        add_idle(1);
        add_frame(8'h55, 2);
        add_frame(8'h0F, 2);
        add_idle(2);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL b2b_wave: first bad sample %0d expected -1", m); end
        read_reg(UART_STATUS, s);
        checks++;
        if (s !== 32'h4) begin errors++; $display("FAIL b2b_status: got %h expected 4", s); end
    endtask

    task automatic test_random_frames();
        logic [31:0] s;
        logic [7:0]  b [3];
        int d, nb, m;
        for (int it = 0; it < 5; it++) begin
            d  = $urandom_range(1, 5);
            nb = $urandom_range(1, (QD + 1 > 3) ? 3 : QD + 1);
            for (int k = 0; k < 3; k++) b[k] = 8'($urandom);
            write_reg(UART_BAUDDIV, 32'(d));
            for (int k = 0; k < nb; k++) begin
                write_reg(UART_TXDATA, {24'd0, b[k]});
                if (k == 0) start_log();
            end
            add_idle(1);
            for (int k = 0; k < nb; k++) add_frame(b[k], d);
            add_idle(2);
            wait_log();
            m = first_mismatch();
            checks++;
            if (m !== -1) begin errors++; $display("FAIL rand_wave[%0d]: first bad sample %0d expected -1 (div %0d, %0d bytes)", it, m, d, nb); end
            read_reg(UART_STATUS, s);
            checks++;
            if (s !== 32'h4) begin errors++; $display("FAIL rand_status[%0d]: got %h expected 4", it, s); end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] s;
        logic [7:0]  b [QD+2];
        int m;
        for (int k = 0; k < QD + 2; k++) b[k] = 8'($urandom);
        write_reg(UART_BAUDDIV, 32'd16);
        for (int k = 0; k < QD + 2; k++) begin
            write_reg(UART_TXDATA, {24'd0, b[k]});
            if (k == 0) start_log();
            if (k == QD) begin
                read_reg(UART_STATUS, s);
                checks++;
                if (s !== 32'h3) begin errors++; $display("FAIL ovr_status_full: got %h expected 3", s); end
            end
        end
        read_reg(UART_STATUS, s);
        checks++;
        if (s !== 32'hB) begin errors++; $display("FAIL ovr_status_set: got %h expected b", s); end
        write_reg(UART_STATUS, 32'd0);
        read_reg(UART_STATUS, s);
        checks++;
        if (s !== 32'h3) begin errors++; $display("FAIL ovr_status_clear: got %h expected 3", s); end
        // The dropped byte must never appear on the line
        add_idle(1);
        for (int k = 0; k < QD + 1; k++) add_frame(b[k], 16);
        add_idle(2);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL ovr_wave: first bad sample %0d expected -1", m); end
        read_reg(UART_STATUS, s);
        checks++;
        if (s !== 32'h4) begin errors++; $display("FAIL ovr_status_end: got %h expected 4", s); end
    endtask

    task automatic test_bauddiv();
        logic [31:0] r;
        logic [7:0]  b0, b1, b2;
        int m;
        b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
        write_reg(UART_BAUDDIV, 32'hFFFF_0000);
        read_reg(UART_BAUDDIV, r);
        checks++;
        if (r !== 32'd1) begin errors++; $display("FAIL baud_zero: got %0d expected 1", r); end
        write_reg(UART_TXDATA, {24'd0, b0});
        start_log();
        add_idle(1);
        add_frame(b0, 1);
        add_idle(2);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL baud_div1_wave: first bad sample %0d expected -1", m); end

        write_reg(UART_BAUDDIV, 32'd3);
        write_reg(UART_TXDATA, {24'd0, b1});
        start_log();
        repeat (5) tick();
        write_reg(UART_BAUDDIV, 32'd2);
        read_reg(UART_BAUDDIV, r);
        checks++;
        if (r !== 32'd2) begin errors++; $display("FAIL baud_midframe_rb: got %0d expected 2", r); end
        add_idle(1);
        add_frame(b1, 3);
        add_idle(2);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL baud_midframe_wave: first bad sample %0d expected -1", m); end

        write_reg(UART_TXDATA, {24'd0, b2});
        start_log();
        add_idle(1);
        add_frame(b2, 2);
        add_idle(2);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL baud_next_frame_wave: first bad sample %0d expected -1", m); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] r;
        logic [7:0]  b0;
        int m;
        b0 = 8'($urandom) & 8'hF7;
        write_reg(UART_BAUDDIV, 32'd4);
        write_reg(UART_TXDATA, {24'd0, b0});
        write_reg(UART_TXDATA, 32'h5A);
        repeat (16) tick();
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL rst_mid_bit3: got %b expected 0", txd); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
        read_reg(UART_STATUS, r);
        checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL rst_mid_status: got %h expected 4", r); end
        read_reg(UART_BAUDDIV, r);
        checks++;
        if (r !== 32'd16) begin errors++; $display("FAIL rst_mid_bauddiv: got %0d expected 16", r); end
        start_log();
        add_idle(60);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL rst_mid_idle_wave: first bad sample %0d expected -1", m); end
    endtask

    task automatic test_unselected();
        logic [31:0] r;
        int m;
        start_log();
        sel = 1'b0; wr = 1'b1; addr = UART_TXDATA; din = 32'hAB;
        #1;
        checks++;
        if (dout !== 32'd0) begin errors++; $display("FAIL unsel_dout_txdata: got %h expected 0", dout); end
        tick();
        addr = UART_BAUDDIV; din = 32'd5;
        #1;
        checks++;
        if (dout !== 32'd0) begin errors++; $display("FAIL unsel_dout_bauddiv: got %h expected 0", dout); end
        tick();
        wr = 1'b0;
        write_reg(2'd3, $urandom);
        read_reg(2'd3, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL reserved_read: got %h expected 0", r); end
        read_reg(UART_STATUS, r);
        checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL unsel_status: got %h expected 4", r); end
        read_reg(UART_BAUDDIV, r);
        checks++;
        if (r !== 32'd16) begin errors++; $display("FAIL unsel_bauddiv: got %0d expected 16", r); end
        add_idle(40);
        wait_log();
        m = first_mismatch();
        checks++;
        if (m !== -1) begin errors++; $display("FAIL unsel_idle_wave: first bad sample %0d expected -1", m); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_random_frames();
        test_overrun();
        test_bauddiv();
        test_reset_mid_frame();
        test_unselected();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
